// File: rtl/mmc_dat_rx_wide.sv
// DAT-line receive deserialiser for 1/4/8-bit MMC/SD buses: assembles bytes,
// checks per-lane CRC16, end bits and the start-bit timeout.
module mmc_dat_rx_wide #(
  parameter int unsigned LEN_W = 12,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bitclk_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [7:0]       data_i,
  input  logic [1:0]       bus_width_i,
  input  logic [LEN_W-1:0] block_len_i,
  input  logic [CNT_W-1:0] block_cnt_i,
  input  logic [TMO_W-1:0] timeout_i,
  output logic             valid_o,
  output logic [7:0]       data_o,
  output logic             active_o,
  output logic             block_done_o,
  output logic             complete_o,
  output logic             crc_err_o,
  output logic             end_err_o,
  output logic             timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_STOP, S_END
  } state_t;

  state_t             state;
  logic               bitclk_q;
  logic [1:0]         lmode;      // 0: 1 lane, 1: 4 lanes, 2: 8 lanes
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   blk_cnt;
  logic [TMO_W-1:0]   tmo_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [LEN_W+2:0]   beat_cnt;
  logic [2:0]         sub_cnt;
  logic [3:0]         crc_cnt;
  logic [6:0]         shreg;
  logic               crc_bad;
  logic [7:0][15:0]   crc_q;

  logic               cap;
  logic [7:0]         lane_mask;
  logic [LEN_W-1:0]   len_m1;
  logic [LEN_W+2:0]   beat_load;
  logic [7:0]         byte_next;
  logic               byte_done;
  logic [TMO_W-1:0]   tmo_inc;
  logic [7:0]         crc_msb;
  logic [7:0][15:0]   crc_upd;
  logic [7:0][15:0]   crc_sh;
  logic               crc_mis;
  logic               end_bad;

  assign cap      = bitclk_i & ~bitclk_q;
  assign active_o = (state != S_IDLE);
  assign tmo_inc  = tmo_cnt + 1'b1;
  // len-1 wraps to all ones for a zero field, which is exactly 2^LEN_W bytes
  assign len_m1   = len_q - 1'b1;

  always_comb begin
    lane_mask = 8'h01;
    beat_load = {len_m1, 3'b111};
    byte_next = {shreg, data_i[0]};
    byte_done = (sub_cnt == 3'd7);
    case (lmode)
      2'd1: begin
        lane_mask = 8'h0F;
        beat_load = {2'b00, len_m1, 1'b1};
        byte_next = {shreg[3:0], data_i[3:0]};
        byte_done = (sub_cnt == 3'd1);
      end
      2'd2: begin
        lane_mask = 8'hFF;
        beat_load = {3'b000, len_m1};
        byte_next = data_i;
        byte_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    crc_upd = '0;
    crc_sh  = '0;
    crc_msb = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      crc_msb[k] = crc_q[k][15];
      crc_sh[k]  = {crc_q[k][14:0], 1'b0};
      crc_upd[k] = crc_sh[k] ^ ({16{crc_q[k][15] ^ data_i[k]}} & 16'h1021);
    end
    crc_mis = |((data_i ^ crc_msb) & lane_mask);
    end_bad = |(~data_i & lane_mask);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      bitclk_q     <= 1'b0;
      lmode        <= '0;
      len_q        <= '0;
      blk_cnt      <= '0;
      tmo_q        <= '0;
      tmo_cnt      <= '0;
      beat_cnt     <= '0;
      sub_cnt      <= '0;
      crc_cnt      <= '0;
      shreg        <= '0;
      crc_bad      <= 1'b0;
      crc_q        <= '0;
      valid_o      <= 1'b0;
      data_o       <= '0;
      block_done_o <= 1'b0;
      complete_o   <= 1'b0;
      crc_err_o    <= 1'b0;
      end_err_o    <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      bitclk_q     <= bitclk_i;
      valid_o      <= 1'b0;
      block_done_o <= 1'b0;
      complete_o   <= 1'b0;
      if (abort_i) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: if (start_i) begin
            lmode     <= (bus_width_i == 2'd3) ? 2'd0 : bus_width_i;
            len_q     <= block_len_i;
            blk_cnt   <= block_cnt_i;
            tmo_q     <= timeout_i;
            tmo_cnt   <= '0;
            crc_err_o <= 1'b0;
            end_err_o <= 1'b0;
            timeout_o <= 1'b0;
            state     <= S_WAIT_START;
          end
          S_WAIT_START: begin
            crc_q   <= '0;
            crc_bad <= 1'b0;
            sub_cnt <= '0;
            if (cap) begin
              if (!data_i[0]) begin
                beat_cnt <= beat_load;
                state    <= S_DATA;
              end else if (tmo_inc >= tmo_q) begin
                timeout_o  <= 1'b1;
                complete_o <= 1'b1;
                state      <= S_END;
              end else begin
                tmo_cnt <= tmo_inc;
              end
            end
          end
          S_DATA: if (cap) begin
            shreg <= byte_next[6:0];
            crc_q <= crc_upd;
            if (byte_done) begin
              valid_o <= 1'b1;
              data_o  <= byte_next;
              sub_cnt <= '0;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
            if (beat_cnt == '0) begin
              crc_cnt <= '0;
              state   <= S_CRC;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
          S_CRC: if (cap) begin
            crc_bad <= crc_bad | crc_mis;
            crc_q   <= crc_sh;
            crc_cnt <= crc_cnt + 1'b1;
            if (crc_cnt == 4'd15) state <= S_STOP;
          end
          S_STOP: if (cap) begin
            if (end_bad) end_err_o <= 1'b1;
            if (crc_bad) crc_err_o <= 1'b1;
            block_done_o <= 1'b1;
            if (blk_cnt == '0) begin
              complete_o <= 1'b1;
              state      <= S_END;
            end else begin
              blk_cnt <= blk_cnt - 1'b1;
              tmo_cnt <= '0;
              state   <= S_WAIT_START;
            end
          end
          S_END: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmc_dat_rx_wide.sv
// Directed bench for mmc_dat_rx_wide: drives bit-clocked DAT frames and checks
// bytes, block/complete pulses and error flags with immediate assertions.
module tb_mmc_dat_rx_wide;
  localparam int unsigned LEN_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             bitclk_i;
  logic             start_i;
  logic             abort_i;
  logic [7:0]       data_i;
  logic [1:0]       bus_width_i;
  logic [LEN_W-1:0] block_len_i;
  logic [CNT_W-1:0] block_cnt_i;
  logic [TMO_W-1:0] timeout_i;
  logic             valid_o;
  logic [7:0]       data_o;
  logic             active_o;
  logic             block_done_o;
  logic             complete_o;
  logic             crc_err_o;
  logic             end_err_o;
  logic             timeout_o;

  mmc_dat_rx_wide #(.LEN_W(LEN_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bitclk_i(bitclk_i), .start_i(start_i),
    .abort_i(abort_i), .data_i(data_i), .bus_width_i(bus_width_i),
    .block_len_i(block_len_i), .block_cnt_i(block_cnt_i), .timeout_i(timeout_i),
    .valid_o(valid_o), .data_o(data_o), .active_o(active_o),
    .block_done_o(block_done_o), .complete_o(complete_o), .crc_err_o(crc_err_o),
    .end_err_o(end_err_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic [7:0]  rxq[$];
  int unsigned n_done = 0;
  int unsigned n_comp = 0;
  always @(negedge clk_i) begin
    if (valid_o)      rxq.push_back(data_o);
    if (block_done_o) n_done++;
    if (complete_o)   n_comp++;
  end

  logic [7:0]  tx[$];
  int unsigned rx0, d0, c0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [7:0] d);
    @(negedge clk_i);
    data_i   = d;
    bitclk_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    bitclk_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_start(input logic [1:0] bw, input logic [LEN_W-1:0] len,
                          input logic [CNT_W-1:0] cnt, input logic [TMO_W-1:0] tmo);
    @(negedge clk_i);
    bus_width_i = bw;
    block_len_i = len;
    block_cnt_i = cnt;
    timeout_i   = tmo;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic snap();
    rx0 = rxq.size();
    d0  = n_done;
    c0  = n_comp;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] lanes_word(input int L, input logic [7:0] bits);
    logic [7:0] mask;
    mask = (L == 1) ? 8'h01 : (L == 4) ? 8'h0F : 8'hFF;
    return (8'hA4 & ~mask) | (bits & mask);
  endfunction

  // Start bit, tx[] as data, then crc_ticks CRC beats; the end bit is left to the caller.
  task automatic send_block(input int L, input int crc_ticks, input logic use_fixed,
                            input logic [15:0] fixed, input int flip_lane, input int flip_bit);
    logic [15:0] c[8];
    logic [7:0]  seq[$];
    logic [7:0]  b, w;
    for (int k = 0; k < 8; k++) c[k] = 16'h0000;
    tick(lanes_word(L, 8'h00));
    foreach (tx[i]) begin
      b = tx[i];
      if (L == 1) begin
        for (int j = 7; j >= 0; j--) seq.push_back(lanes_word(1, {7'b0, b[j]}));
      end else if (L == 4) begin
        seq.push_back(lanes_word(4, {4'h0, b[7:4]}));
        seq.push_back(lanes_word(4, {4'h0, b[3:0]}));
      end else begin
        seq.push_back(b);
      end
    end
    foreach (seq[i]) begin
      w = seq[i];
      tick(w);
      for (int k = 0; k < L; k++)
        c[k] = {c[k][14:0], 1'b0} ^ ((c[k][15] ^ w[k]) ? 16'h1021 : 16'h0000);
    end
    if (use_fixed) c[0] = fixed;
    if (flip_lane >= 0) c[flip_lane][flip_bit] = ~c[flip_lane][flip_bit];
    for (int i = 0; i < crc_ticks; i++) begin
      w = 8'h00;
      for (int k = 0; k < L; k++) w[k] = c[k][15-i];
      tick(lanes_word(L, w));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned bad;
    logic [7:0] exp2 [8];
    rst_ni = 1'b0; bitclk_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; data_i = 8'hFF;
    bus_width_i = '0; block_len_i = '0; block_cnt_i = '0; timeout_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_active", active_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_flags", {crc_err_o, end_err_o, timeout_o, block_done_o, complete_o}, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 1-bit, 512 bytes of 0xFF, published CRC 0x7FA1
    snap();
    do_start(2'd0, 12'd512, 8'd0, 16'd1000);
    check("t1_active", active_o, 1);
    tx.delete();
    for (int i = 0; i < 512; i++) tx.push_back(8'hFF);
    tick(8'hFF);
    send_block(1, 16, 1'b1, 16'h7FA1, -1, 0);
    tick(8'hFF);
    settle();
    bad = 0;
    for (int i = 0; i < 512; i++) if (rx0 + i < rxq.size() && rxq[rx0+i] !== 8'hFF) bad++;
    check("t1_nbytes", rxq.size() - rx0, 512);
    check("t1_badbytes", bad, 0);
    check("t1_done", n_done - d0, 1);
    check("t1_complete", n_comp - c0, 1);
    check("t1_flags", {crc_err_o, end_err_o, timeout_o}, 0);
    check("t1_idle", active_o, 0);

    // 4-bit, 2 blocks of 4 bytes; a start_i mid-transfer must be ignored
    snap();
    do_start(2'd1, 12'd4, 8'd1, 16'd1000);
    tx = '{8'h12, 8'h34, 8'h56, 8'h78};
    tick(8'hFF);
    send_block(4, 16, 1'b0, 16'h0, -1, 0);
    tick(8'hFF);
    do_start(2'd2, 12'd1, 8'd0, 16'd1000);
    tick(8'hFF);
    send_block(4, 16, 1'b0, 16'h0, -1, 0);
    tick(8'hFF);
    settle();
    exp2 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h12, 8'h34, 8'h56, 8'h78};
    check("t2_nbytes", rxq.size() - rx0, 8);
    for (int i = 0; i < 8; i++)
      if (rx0 + i < rxq.size()) check($sformatf("t2_byte%0d", i), rxq[rx0+i], exp2[i]);
    check("t2_done", n_done - d0, 2);
    check("t2_complete", n_comp - c0, 1);
    check("t2_flags", {crc_err_o, end_err_o, timeout_o}, 0);

    // 8-bit, lane 3 CRC LSB corrupted
    snap();
    do_start(2'd2, 12'd2, 8'd0, 16'd1000);
    tx = '{8'hA5, 8'h5A};
    tick(8'hFF);
    send_block(8, 16, 1'b0, 16'h0, 3, 0);
    check("t3_crc_before_stop", crc_err_o, 0);
    tick(8'hFF);
    settle();
    check("t3_nbytes", rxq.size() - rx0, 2);
    if (rx0 + 1 < rxq.size()) begin
      check("t3_byte0", rxq[rx0], 8'hA5);
      check("t3_byte1", rxq[rx0+1], 8'h5A);
    end
    check("t3_crc_err", crc_err_o, 1);
    check("t3_end_err", end_err_o, 0);
    check("t3_complete", n_comp - c0, 1);

    // 1-bit, start-bit timeout after 10 caps
    snap();
    do_start(2'd0, 12'd1, 8'd0, 16'd10);
    repeat (9) tick(8'h01);
    check("t4_tmo_early", timeout_o, 0);
    check("t4_active_early", active_o, 1);
    tick(8'h01);
    settle();
    check("t4_timeout", timeout_o, 1);
    check("t4_complete", n_comp - c0, 1);
    check("t4_novalid", rxq.size() - rx0, 0);
    check("t4_idle", active_o, 0);

    // 4-bit abort after 3 bytes, then a clean block
    snap();
    do_start(2'd1, 12'd4, 8'd0, 16'd1000);
    tick(8'h00);
    tick(8'h01); tick(8'h02); tick(8'h03); tick(8'h04); tick(8'h05); tick(8'h06);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("t5_abort_idle", active_o, 0);
    settle();
    check("t5_nbytes", rxq.size() - rx0, 3);
    check("t5_no_complete", n_comp - c0, 0);
    snap();
    do_start(2'd1, 12'd4, 8'd0, 16'd1000);
    tx = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    tick(8'hFF);
    send_block(4, 16, 1'b0, 16'h0, -1, 0);
    tick(8'hFF);
    settle();
    check("t5_nbytes2", rxq.size() - rx0, 4);
    if (rx0 + 3 < rxq.size()) check("t5_last", rxq[rx0+3], 8'hF0);
    check("t5_flags", {crc_err_o, end_err_o, timeout_o}, 0);
    check("t5_complete", n_comp - c0, 1);

    // Asynchronous reset in the middle of the CRC field
    do_start(2'd0, 12'd1, 8'd0, 16'd1000);
    tx = '{8'hC3};
    send_block(1, 5, 1'b0, 16'h0, -1, 0);
    check("t6_data_pre", data_o, 8'hC3);
    check("t6_active_pre", active_o, 1);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_active", active_o, 0);
    check("t6_rst_data", data_o, 0);
    check("t6_rst_misc", {valid_o, block_done_o, complete_o, crc_err_o, end_err_o, timeout_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 4-bit, end bit low on lane 0
    snap();
    do_start(2'd1, 12'd1, 8'd0, 16'd1000);
    tx = '{8'h3C};
    tick(8'hFF);
    send_block(4, 16, 1'b0, 16'h0, -1, 0);
    tick(8'hFE);
    settle();
    check("t7_end_err", end_err_o, 1);
    check("t7_crc_err", crc_err_o, 0);
    check("t7_done", n_done - d0, 1);
    check("t7_complete", n_comp - c0, 1);
    if (rx0 < rxq.size()) check("t7_byte", rxq[rx0], 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
